// File: rtl/memr_if.sv
// memr_if: bus bundle between the memr stage, the cushion stage, the MMU data port and writeback.
// Ports: none; the slave modport is the memr side, the master modport is the surrounding core/MMU side.
interface memr_if;
  logic        FLUSH;
  logic        STALL;
  logic [4:0]  cushion_reg_w_rd;
  logic [31:0] cushion_reg_w_data;
  logic [11:0] cushion_csr_w_addr;
  logic [31:0] cushion_csr_w_data;
  logic        cushion_mem_r_valid;
  logic [4:0]  cushion_mem_r_rd;
  logic [31:0] cushion_mem_r_addr;
  logic [3:0]  cushion_mem_r_strb;
  logic        cushion_mem_r_signed;
  logic        cushion_mem_w_valid;
  logic [31:0] cushion_mem_w_addr;
  logic [3:0]  cushion_mem_w_strb;
  logic [31:0] cushion_mem_w_data;
  logic        cushion_jmp_do;
  logic [31:0] cushion_jmp_pc;
  logic        MEM_WAIT;
  logic        DATA_RDEN;
  logic [31:0] DATA_RIADDR;
  logic        DATA_RVALID;
  logic [31:0] DATA_ROADDR;
  logic [31:0] DATA_RDATA;
  logic [4:0]  memr_reg_w_rd;
  logic [31:0] memr_reg_w_data;
  logic [11:0] memr_csr_w_addr;
  logic [31:0] memr_csr_w_data;
  logic        memr_mem_w_valid;
  logic [31:0] memr_mem_w_addr;
  logic [3:0]  memr_mem_w_strb;
  logic [31:0] memr_mem_w_data;
  logic        memr_jmp_do;
  logic [31:0] memr_jmp_pc;
  modport slave (
    input  FLUSH, cushion_reg_w_rd, cushion_reg_w_data, cushion_csr_w_addr, cushion_csr_w_data,
           cushion_mem_r_valid, cushion_mem_r_rd, cushion_mem_r_addr, cushion_mem_r_strb,
           cushion_mem_r_signed, cushion_mem_w_valid, cushion_mem_w_addr, cushion_mem_w_strb,
           cushion_mem_w_data, cushion_jmp_do, cushion_jmp_pc, MEM_WAIT, DATA_RVALID,
           DATA_ROADDR, DATA_RDATA,
    output STALL, DATA_RDEN, DATA_RIADDR, memr_reg_w_rd, memr_reg_w_data, memr_csr_w_addr,
           memr_csr_w_data, memr_mem_w_valid, memr_mem_w_addr, memr_mem_w_strb, memr_mem_w_data,
           memr_jmp_do, memr_jmp_pc
  );
  modport master (
    output FLUSH, cushion_reg_w_rd, cushion_reg_w_data, cushion_csr_w_addr, cushion_csr_w_data,
           cushion_mem_r_valid, cushion_mem_r_rd, cushion_mem_r_addr, cushion_mem_r_strb,
           cushion_mem_r_signed, cushion_mem_w_valid, cushion_mem_w_addr, cushion_mem_w_strb,
           cushion_mem_w_data, cushion_jmp_do, cushion_jmp_pc, MEM_WAIT, DATA_RVALID,
           DATA_ROADDR, DATA_RDATA,
    input  STALL, DATA_RDEN, DATA_RIADDR, memr_reg_w_rd, memr_reg_w_data, memr_csr_w_addr,
           memr_csr_w_data, memr_mem_w_valid, memr_mem_w_addr, memr_mem_w_strb, memr_mem_w_data,
           memr_jmp_do, memr_jmp_pc
  );
endinterface

// File: rtl/memr.sv
// memr: memory-read stage; issues loads to the MMU data port, extracts/extends the result, passes other ops through one cycle.
// Ports: CLK core clock, RST sync active-high reset, bus (memr_if.slave) carrying cushion inputs, MMU read port and memr_* outputs.
module memr (
  input logic   CLK,
  input logic   RST,
  memr_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
  state_t state;
  logic match, pass, done;
  logic [31:0] d, ld_data;
  always_comb begin
    match = bus.DATA_RVALID && bus.DATA_ROADDR == bus.cushion_mem_r_addr;
    pass = (state == IDLE || state == DRAIN) && !bus.cushion_mem_r_valid && !bus.FLUSH;
    done = state == WAIT && match && !bus.FLUSH;
    d = bus.DATA_RDATA >> {bus.cushion_mem_r_addr[1:0], 3'b000};
    ld_data = bus.cushion_mem_r_strb == 4'b0001 ? {{24{bus.cushion_mem_r_signed & d[7]}}, d[7:0]} :
              bus.cushion_mem_r_strb == 4'b0011 ? {{16{bus.cushion_mem_r_signed & d[15]}}, d[15:0]} :
              bus.DATA_RDATA;
    bus.STALL = (state == IDLE && bus.cushion_mem_r_valid) || state == REQ ||
                (state == WAIT && !match) || (state == DRAIN && bus.cushion_mem_r_valid);
    bus.DATA_RDEN = state == REQ;
    bus.DATA_RIADDR = state == REQ ? bus.cushion_mem_r_addr : '0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      bus.memr_reg_w_rd <= '0;
      bus.memr_reg_w_data <= '0;
      bus.memr_csr_w_addr <= '0;
      bus.memr_csr_w_data <= '0;
      bus.memr_mem_w_valid <= 1'b0;
      bus.memr_mem_w_addr <= '0;
      bus.memr_mem_w_strb <= '0;
      bus.memr_mem_w_data <= '0;
      bus.memr_jmp_do <= 1'b0;
      bus.memr_jmp_pc <= '0;
    end else begin
      case (state)
        IDLE:  state <= bus.cushion_mem_r_valid && !bus.FLUSH ? REQ : IDLE;
        REQ:   state <= bus.MEM_WAIT ? (bus.FLUSH ? IDLE : REQ) : (bus.FLUSH ? DRAIN : WAIT);
        WAIT:  state <= match ? IDLE : bus.FLUSH ? DRAIN : WAIT;
        DRAIN: state <= bus.DATA_RVALID ? IDLE : DRAIN;
      endcase
      bus.memr_reg_w_rd <= pass ? bus.cushion_reg_w_rd : done ? bus.cushion_mem_r_rd : '0;
      bus.memr_reg_w_data <= pass ? bus.cushion_reg_w_data : done ? ld_data : '0;
      bus.memr_csr_w_addr <= pass ? bus.cushion_csr_w_addr : '0;
      bus.memr_csr_w_data <= pass ? bus.cushion_csr_w_data : '0;
      bus.memr_mem_w_valid <= pass && bus.cushion_mem_w_valid;
      bus.memr_mem_w_addr <= pass ? bus.cushion_mem_w_addr : '0;
      bus.memr_mem_w_strb <= pass ? bus.cushion_mem_w_strb : '0;
      bus.memr_mem_w_data <= pass ? bus.cushion_mem_w_data : '0;
      bus.memr_jmp_do <= pass && bus.cushion_jmp_do;
      bus.memr_jmp_pc <= pass ? bus.cushion_jmp_pc : '0;
    end
  end
endmodule
